// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and sizing for the pipelined-multiplier issue/completion scheduler.
// One slot per cycle of multiplier latency, each tagged with its destination register.
package mul_issue_ctrl_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned RA_W            = 5;
    localparam int unsigned MUL_LATENCY_DEF = 5;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
    } mul_slot_t;

    // True when an in-flight slot will write the (non-zero) register r.
    function automatic logic slot_match(input mul_slot_t s, input logic [RA_W-1:0] r);
        return s.v && (s.rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// EX-stage <-> MUL issue controller signal bundle.
// master = EX pipeline / multiplier side, slave = the controller.
interface mul_issue_ctrl_if;
    import mul_issue_ctrl_pkg::*;

    logic            issue_valid;
    logic            issue_is_mul;
    logic            issue_writes_rd;
    logic [RA_W-1:0] issue_rd;
    logic            issue_uses_rs1;
    logic [RA_W-1:0] issue_rs1;
    logic            issue_uses_rs2;
    logic [RA_W-1:0] issue_rs2;
    logic            flush;
    logic [XLEN-1:0] alu_result;
    logic            mul_valid_out;
    logic [XLEN-1:0] mul_result;

    logic            mul_start;
    logic            stall_ex;
    logic            result_valid;
    logic            result_from_mul;
    logic [RA_W-1:0] result_rd;
    logic [XLEN-1:0] result_data;
    logic            busy;
    logic            seq_error;

    modport master (
        output issue_valid, issue_is_mul, issue_writes_rd, issue_rd,
               issue_uses_rs1, issue_rs1, issue_uses_rs2, issue_rs2,
               flush, alu_result, mul_valid_out, mul_result,
        input  mul_start, stall_ex, result_valid, result_from_mul,
               result_rd, result_data, busy, seq_error
    );

    modport slave (
        input  issue_valid, issue_is_mul, issue_writes_rd, issue_rd,
               issue_uses_rs1, issue_rs1, issue_uses_rs2, issue_rs2,
               flush, alu_result, mul_valid_out, mul_result,
        output mul_start, stall_ex, result_valid, result_from_mul,
               result_rd, result_data, busy, seq_error
    );

endinterface

// File: rtl/mul_issue_ctrl_slot_tracker.sv
// Latency-deep shift register of in-flight MUL destinations with hazard comparators.
// slot[0] is the MUL completing this cycle; it is never reported as a hazard (WB bypass covers it).
module mul_issue_ctrl_slot_tracker
    import mul_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_v,
    input  logic [RA_W-1:0]        push_rd,
    input  logic [RA_W-1:0]        rs1,
    input  logic [RA_W-1:0]        rs2,
    input  logic [RA_W-1:0]        rd,
    output mul_slot_t              slot0,
    output logic [MUL_LATENCY-2:0] later,
    output logic [MUL_LATENCY-1:0] hit_rs1,
    output logic [MUL_LATENCY-1:0] hit_rs2,
    output logic [MUL_LATENCY-1:0] hit_rd,
    output logic                   busy
);

    mul_slot_t slot_q [MUL_LATENCY];

    // Advance one slot per cycle; newly accepted MUL enters at the far end.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < MUL_LATENCY; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < MUL_LATENCY - 1; k++) begin
                slot_q[k] <= slot_q[k+1];
            end
            slot_q[MUL_LATENCY-1] <= mul_slot_t'{v: push_v, rd: push_rd};
        end
    end

    always_comb begin
        hit_rs1 = '0;
        hit_rs2 = '0;
        hit_rd  = '0;
        later   = '0;
        busy    = slot_q[0].v;
        for (int unsigned k = 1; k < MUL_LATENCY; k++) begin
            hit_rs1[k]  = slot_match(slot_q[k], rs1);
            hit_rs2[k]  = slot_match(slot_q[k], rs2);
            hit_rd[k]   = slot_match(slot_q[k], rd);
            later[k-1]  = slot_q[k].v;
            busy        = busy | slot_q[k].v;
        end
    end

    assign slot0 = slot_q[0];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/completion scheduler for the fixed-latency pipelined multiplier in EX.
// Stalls EX on RAW/WAW against in-flight MULs and arbitrates the EX->MEM result slot.
module mul_issue_ctrl
    import mul_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF
) (
    input logic          clock,
    input logic          reset,
    mul_issue_ctrl_if.slave bus
);

    localparam int unsigned GHOST_W = MUL_LATENCY - 1;

    mul_slot_t              slot0;
    logic [GHOST_W-1:0]     later;
    logic [MUL_LATENCY-1:0] hit_rs1;
    logic [MUL_LATENCY-1:0] hit_rs2;
    logic [MUL_LATENCY-1:0] hit_rd;
    logic                   busy;

    logic live;
    logic raw;
    logic waw;
    logic structural;
    logic stall;
    logic accept;
    logic accept_mul;
    logic mismatch;

    logic               seq_error_q;
    logic [GHOST_W-1:0] ghost_q;

    mul_issue_ctrl_slot_tracker #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_tracker (
        .clock   (clock),
        .reset   (reset),
        .push_v  (accept_mul),
        .push_rd (bus.issue_rd),
        .rs1     (bus.issue_rs1),
        .rs2     (bus.issue_rs2),
        .rd      (bus.issue_rd),
        .slot0   (slot0),
        .later   (later),
        .hit_rs1 (hit_rs1),
        .hit_rs2 (hit_rs2),
        .hit_rd  (hit_rd),
        .busy    (busy)
    );

    // Hazard detection; a MUL never needs the result slot now, so it is exempt from the structural stall.
    always_comb begin
        live       = bus.issue_valid & ~bus.flush;
        raw        = (bus.issue_uses_rs1 & (|hit_rs1)) | (bus.issue_uses_rs2 & (|hit_rs2));
        waw        = bus.issue_writes_rd & (|hit_rd);
        structural = ~bus.issue_is_mul & slot0.v;
        stall      = live & (raw | waw | structural);
        accept     = live & ~stall;
        accept_mul = accept & bus.issue_is_mul;
    end

    // Result slot: completing MUL wins, then an accepted ALU op, else a bubble.
    always_comb begin
        bus.result_valid    = 1'b0;
        bus.result_from_mul = 1'b0;
        bus.result_rd       = '0;
        bus.result_data     = '0;
        if (slot0.v) begin
            bus.result_valid    = 1'b1;
            bus.result_from_mul = 1'b1;
            bus.result_rd       = slot0.rd;
            bus.result_data     = bus.mul_result;
        end else if (accept & ~bus.issue_is_mul) begin
            bus.result_valid    = 1'b1;
            bus.result_rd       = bus.issue_rd;
            bus.result_data     = bus.alu_result;
        end
    end

    assign bus.mul_start = accept_mul;
    assign bus.stall_ex  = stall;
    assign bus.busy      = busy;
    assign bus.seq_error = seq_error_q;

    // Strobes belonging to MULs discarded by a reset are expected; ghost_q[0] marks such a cycle.
    assign mismatch = (bus.mul_valid_out != slot0.v)
                    && !(bus.mul_valid_out && !slot0.v && ghost_q[0]);

    always_ff @(posedge clock) begin
        if (reset) begin
            seq_error_q <= 1'b0;
            ghost_q     <= (ghost_q >> 1) | later;
        end else begin
            ghost_q <= ghost_q >> 1;
            if (mismatch) begin
                seq_error_q <= 1'b1;
            end
        end
    end

endmodule
